// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator running in the clk domain.
// Horizontal/vertical counters advance on rising edges of the divided pixel_clock
// while enable is high. Sync, blanking and frame-start outputs are registered
// decodes of the current position, so they trail the counters by one clk.
// Optional build macro: FRAME_COUNT_EN adds an 8-bit frame_count output.
//
// state | meaning
// H_ACT | visible pixels of the line
// H_FRT | horizontal front porch
// H_SYN | horizontal sync pulse (hsync low)
// H_BCK | horizontal back porch, wraps to H_ACT
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_clock,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FRT_LAST  = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYN_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_LIM   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYN_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {H_ACT, H_FRT, H_SYN, H_BCK} h_state_e;

  h_state_e   state_q;
  logic       pclk_d_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick, adv, h_wrap, v_wrap;
  logic       hsync_q, vsync_q, video_on_q, frame_wrap_q, frame_start_q;

  // Tick detection and next-position arithmetic for the raster counters.
  always_comb begin
    tick   = pixel_clock & ~pclk_d_q;
    adv    = tick & enable;
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (adv) begin
      if (h_wrap) begin
        x_d = '0;
        y_d = v_wrap ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Pixel-clock delay line and position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_d_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      pclk_d_q <= pixel_clock;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Horizontal region FSM, stepping in lockstep with pixel_x.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= H_ACT;
    end else if (adv) begin
      case (state_q)
        H_ACT:   if (x_q == H_ACT_LAST) state_q <= H_FRT;
        H_FRT:   if (x_q == H_FRT_LAST) state_q <= H_SYN;
        H_SYN:   if (x_q == H_SYN_LAST) state_q <= H_BCK;
        H_BCK:   if (h_wrap)            state_q <= H_ACT;
        default:                        state_q <= H_ACT;
      endcase
    end
  end

  // Registered decode of the current position into the video outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_wrap_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (state_q != H_SYN);
      vsync_q       <= !((y_q >= V_SYN_FIRST) && (y_q <= V_SYN_LAST));
      video_on_q    <= (state_q == H_ACT) && (y_q < V_ACT_LIM);
      frame_wrap_q  <= adv & h_wrap & v_wrap;
      frame_start_q <= frame_wrap_q;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign frame_start = frame_start_q;

`ifdef FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  // Frame counter bumps in the same cycle the counters wrap to (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else if (adv & h_wrap & v_wrap) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a reduced raster so whole frames
// fit in a short run. The reference model tracks only the number of qualifying
// ticks since reset and derives position, syncs and frame count arithmetically.
module tb_vga_timing_ctrl;
  localparam int HA = 6, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
`ifdef FRAME_COUNT_EN
  localparam int FAST_FRAMES = 258;
`else
  localparam int FAST_FRAMES = 20;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_clock;
  logic       enable;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
`ifdef FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pixel_clock(pixel_clock), .enable(enable),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
`ifdef FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, hs, vs, vo, fs, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   n = 0;
  bit   prev_pc = 1'b0;
  bit   last_wrap = 1'b0;
  int   exp_frames = 0, obs_frames = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Called at a negedge: drive inputs, predict the state after the next posedge.
  task automatic step(input bit pc, input bit en);
    exp_t e;
    int ox, oy;
    pixel_clock = pc;
    enable      = en;
    ox   = n % HT;
    oy   = (n / HT) % VT;
    e.hs = !(ox >= HA + HF && ox < HA + HF + HS);
    e.vs = !(oy >= VA + VF && oy < VA + VF + VS);
    e.vo = (ox < HA) && (oy < VA);
    e.fs = last_wrap;
    if (pc && !prev_pc && en) begin
      n++;
      last_wrap = (n % FR == 0);
    end else begin
      last_wrap = 1'b0;
    end
    prev_pc = pc;
    if (last_wrap) exp_frames++;
    e.x  = n % HT;
    e.y  = (n / HT) % VT;
    e.fc = (n / FR) % 256;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_frame_start", int'(frame_start), 0);
`ifdef FRAME_COUNT_EN
    chk("rst_frame_count", int'(frame_count), 0);
`endif
    n         = 0;
    prev_pc   = 1'b0;
    last_wrap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_frame_start", int'(frame_start), 0);
    chk("rst_hold_video_on", int'(video_on), 0);
    reset = 1'b1;
  endtask

  // Monitor: one expected record per clk edge outside reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pixel_x", int'(pixel_x), e.x);
        chk("pixel_y", int'(pixel_y), e.y);
        chk("hsync", int'(hsync), e.hs);
        chk("vsync", int'(vsync), e.vs);
        chk("video_on", int'(video_on), e.vo);
        chk("frame_start", int'(frame_start), e.fs);
`ifdef FRAME_COUNT_EN
        chk("frame_count", int'(frame_count), e.fc);
`endif
        if (frame_start === 1'b1) obs_frames++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cx, cy;
    reset       = 1'b0;
    pixel_clock = 1'b0;
    enable      = 1'b0;
    @(negedge clk);
    do_reset();

    // clk/8 pixel clock right after reset release
    for (int i = 0; i < 320; i++) step((i % 8) < 4, 1'b1);
    // hold with enable low for 50 pixel periods, then resume
    for (int i = 0; i < 400; i++) step((i % 8) < 4, 1'b0);
    for (int i = 0; i < 80; i++) step((i % 8) < 4, 1'b1);
    // randomized pixel clock and enable
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0);

    // drive into the hsync+vsync window, then reset asynchronously
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      cx = n % HT;
      cy = (n / HT) % VT;
      if (cx >= HA + HF && cx < HA + HF + HS && cy >= VA + VF && cy < VA + VF + VS)
        found = 1'b1;
    end
    chk("reset_target_found", int'(found), 1);
    step(1'b0, 1'b0);
    chk("pre_reset_vsync_low", int'(vsync), found ? 0 : int'(vsync));
    chk("pre_reset_hsync_low", int'(hsync), found ? 0 : int'(hsync));
    do_reset();

    // fast pixel clock, many whole frames
    for (int i = 0; i < FAST_FRAMES * FR * 2; i++) step(i % 2 == 0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("frame_start_count", obs_frames, exp_frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
